// File: rtl/puf_uart_pkg.sv
// Shared types and constants for the PUF response UART framing path.
// Frame = header byte, response bytes, one XOR checksum byte.
package puf_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  function automatic int frame_len(input int resp_bytes);
    return resp_bytes + 2;
  endfunction

endpackage

// File: rtl/puf_resp_sender.sv
// Serialises one PUF response word into a framed byte stream for a UART
// transmitter, handshaking each byte on tx_send / tx_busy.
module puf_resp_sender
  import puf_uart_pkg::*;
#(
  parameter int         RESP_BYTES  = 8,
  parameter logic [7:0] HEADER      = HEADER_DEFAULT,
  parameter int         ACK_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*RESP_BYTES-1:0] resp_data,
  input  logic                    resp_valid,
  output logic                    resp_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_send,
  input  logic                    tx_busy,
  output logic                    frame_done,
  output logic                    ack_err
);

  localparam int             FLEN     = frame_len(RESP_BYTES);
  localparam int             IW       = $clog2(FLEN);
  localparam int             CW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [IW-1:0]  LAST_IDX = IW'(FLEN - 1);
  localparam logic [IW-1:0]  NBYTES   = IW'(RESP_BYTES);
  localparam logic [CW-1:0]  TMO      = CW'(ACK_TIMEOUT);

  state_e                  state_q, state_d;
  logic [8*RESP_BYTES-1:0] resp_q, resp_d;
  logic [7:0]              chk_q, chk_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    tx_send_q, tx_send_d;
  logic                    frame_done_q, frame_done_d;
  logic                    ack_err_q, ack_err_d;
  logic                    resp_ready_q, resp_ready_d;

  logic [IW-1:0]           rev_idx;
  logic [8*RESP_BYTES-1:0] resp_sh;
  logic [7:0]              cur_byte;

  // Index 0 is the header, 1..RESP_BYTES walk the response MSB-first,
  // the last index is the checksum.
  always_comb begin
    rev_idx  = NBYTES - idx_q;
    resp_sh  = resp_q >> {rev_idx, 3'b000};
    cur_byte = HEADER;
    if (idx_q == LAST_IDX)  cur_byte = chk_q;
    else if (idx_q != '0)   cur_byte = resp_sh[7:0];
  end

  always_comb begin
    state_d      = state_q;
    resp_d       = resp_q;
    chk_d        = chk_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    tx_data_d    = tx_data_q;
    tx_send_d    = 1'b0;
    frame_done_d = 1'b0;
    ack_err_d    = ack_err_q;
    case (state_q)
      IDLE: begin
        if (resp_valid && resp_ready_q) begin
          resp_d    = resp_data;
          chk_d     = '0;
          idx_d     = '0;
          cnt_d     = '0;
          ack_err_d = 1'b0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (!tx_busy) begin
          tx_send_d = 1'b1;
          tx_data_d = cur_byte;
          cnt_d     = '0;
          if (idx_q != '0 && idx_q != LAST_IDX) chk_d = chk_q ^ cur_byte;
          state_d   = ACK;
        end
      end
      ACK: begin
        if (tx_busy) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else if (cnt_q >= TMO - CW'(1)) begin
          // Transmitter never acknowledged: drop the frame, keep the flag.
          cnt_d     = TMO;
          ack_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (!tx_busy) begin
          if (idx_q == LAST_IDX) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    resp_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      resp_q       <= '0;
      chk_q        <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      tx_data_q    <= '0;
      tx_send_q    <= 1'b0;
      frame_done_q <= 1'b0;
      ack_err_q    <= 1'b0;
      resp_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      resp_q       <= resp_d;
      chk_q        <= chk_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      tx_data_q    <= tx_data_d;
      tx_send_q    <= tx_send_d;
      frame_done_q <= frame_done_d;
      ack_err_q    <= ack_err_d;
      resp_ready_q <= resp_ready_d;
    end
  end

  assign resp_ready = resp_ready_q;
  assign tx_data    = tx_data_q;
  assign tx_send    = tx_send_q;
  assign frame_done = frame_done_q;
  assign ack_err    = ack_err_q;

endmodule

// File: tb/tb_puf_resp_sender.sv
// Bench for puf_resp_sender: an 8-byte and a 1-byte instance, each fed by a
// behavioural UART stand-in that records sent bytes and holds tx_busy.
module tb_puf_resp_sender;
  import puf_uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [63:0] resp_data8 = '0;
  logic        resp_valid8 = 1'b0;
  logic        resp_ready8, tx_send8, tx_busy8, frame_done8, ack_err8;
  logic [7:0]  tx_data8;

  logic [7:0]  resp_data1 = '0;
  logic        resp_valid1 = 1'b0;
  logic        resp_ready1, tx_send1, tx_busy1, frame_done1, ack_err1;
  logic [7:0]  tx_data1;

  puf_resp_sender #(.RESP_BYTES(8), .HEADER(8'hA5), .ACK_TIMEOUT(15)) dut8 (
    .clk(clk), .rst(rst), .resp_data(resp_data8), .resp_valid(resp_valid8),
    .resp_ready(resp_ready8), .tx_data(tx_data8), .tx_send(tx_send8),
    .tx_busy(tx_busy8), .frame_done(frame_done8), .ack_err(ack_err8));

  puf_resp_sender #(.RESP_BYTES(1), .HEADER(8'hA5), .ACK_TIMEOUT(15)) dut1 (
    .clk(clk), .rst(rst), .resp_data(resp_data1), .resp_valid(resp_valid1),
    .resp_ready(resp_ready1), .tx_data(tx_data1), .tx_send(tx_send1),
    .tx_busy(tx_busy1), .frame_done(frame_done1), .ack_err(ack_err1));

  // UART stand-ins: a send starts a busy window of blen cycles.
  logic       hold8 = 1'b0, tie0_8 = 1'b0;
  int         blen8 = 160, cnt8 = 0, fd_cnt8 = 0, send_cnt8 = 0;
  logic [7:0] cap8[$];
  assign tx_busy8 = hold8 | ((cnt8 != 0) & ~tie0_8);

  always @(negedge clk) begin
    if (tx_send8) send_cnt8 <= send_cnt8 + 1;
    if (tx_send8 && !tie0_8) begin
      cap8.push_back(tx_data8);
      cnt8 <= blen8;
    end else if (cnt8 != 0) cnt8 <= cnt8 - 1;
    if (frame_done8) fd_cnt8 <= fd_cnt8 + 1;
  end

  int         blen1 = 4, cnt1 = 0, fd_cnt1 = 0;
  logic [7:0] cap1[$];
  assign tx_busy1 = (cnt1 != 0);

  always @(negedge clk) begin
    if (tx_send1) begin
      cap1.push_back(tx_data1);
      cnt1 <= blen1;
    end else if (cnt1 != 0) cnt1 <= cnt1 - 1;
    if (frame_done1) fd_cnt1 <= fd_cnt1 + 1;
  end

  int tests = 0, fails = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame: header, bytes MSB-first, XOR of the response bytes.
  task automatic model_frame(input logic [127:0] d, input int nb);
    logic [7:0] c, b;
    c = 8'h00;
    exp_q.delete();
    exp_q.push_back(HEADER_DEFAULT);
    for (int k = 0; k < nb; k++) begin
      b = d[8*(nb-1-k) +: 8];
      exp_q.push_back(b);
      c = c ^ b;
    end
    exp_q.push_back(c);
  endtask

  task automatic check_cap(input string name, input bit sel, input int base,
                           input int nb, input logic [127:0] d);
    int sz;
    logic [7:0] a;
    model_frame(d, nb);
    sz = sel ? cap1.size() : cap8.size();
    check({name, " len"}, 64'(sz - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < sz) begin
        a = sel ? cap1[base+i] : cap8[base+i];
        check($sformatf("%s byte%0d", name, i), 64'(a), 64'(exp_q[i]));
      end
    end
  endtask

  task automatic accept8(input string name, input logic [63:0] d, input bit lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!resp_ready8 && w < 2000) begin @(negedge clk); w++; end
    check({name, " ready"}, 64'(resp_ready8), 64'd1);
    resp_data8 = d; resp_valid8 = 1'b1;
    @(posedge clk); @(negedge clk);
    resp_valid8 = 1'b0;
    check({name, " busy-ready"}, 64'(resp_ready8), 64'd0);
    check({name, " err-clr"}, 64'(ack_err8), 64'd0);
    if (lat) begin
      check({name, " send-early"}, 64'(tx_send8), 64'd0);
      @(posedge clk); @(negedge clk);
      check({name, " latency"}, 64'(tx_send8), 64'd1);
      check({name, " hdr"}, 64'(tx_data8), 64'hA5);
    end
  endtask

  task automatic wait_fd8(input string name, input int fdb);
    int n;
    n = 0;
    while (fd_cnt8 == fdb && n < 5000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check({name, " done"}, 64'(fd_cnt8 - fdb), 64'd1);
    check({name, " ready-end"}, 64'(resp_ready8), 64'd1);
  endtask

  task automatic run_frame8(input string name, input logic [63:0] d, input bit lat);
    int base, fdb;
    base = cap8.size(); fdb = fd_cnt8;
    accept8(name, d, lat);
    wait_fd8(name, fdb);
    check_cap(name, 1'b0, base, 8, {64'h0, d});
  endtask

  task automatic run_frame1(input string name, input logic [7:0] d);
    int base, fdb, n;
    base = cap1.size(); fdb = fd_cnt1; n = 0;
    @(negedge clk);
    resp_data1 = d; resp_valid1 = 1'b1;
    @(posedge clk); @(negedge clk);
    resp_valid1 = 1'b0;
    check({name, " busy-ready"}, 64'(resp_ready1), 64'd0);
    while (fd_cnt1 == fdb && n < 2000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check({name, " done"}, 64'(fd_cnt1 - fdb), 64'd1);
    check_cap(name, 1'b1, base, 1, {120'h0, d});
  endtask

  typedef struct {
    logic [63:0] d;
    int          blen;
    logic [7:0]  chk;
  } vec_t;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    vec_t tbl[6];
    int   base, fdb, sc, n, sends;
    logic [63:0] d;

    tbl[0] = '{64'hDEADBEEF00000000, 3,  8'h22};
    tbl[1] = '{64'h0000000000000001, 1,  8'h01};
    tbl[2] = '{64'hFFFFFFFFFFFFFFFF, 7,  8'h00};
    tbl[3] = '{64'h0102030405060708, 2,  8'h08};
    tbl[4] = '{64'h123456789ABCDEF0, 10, 8'h00};
    tbl[5] = '{64'h8000000000000000, 5,  8'h80};

    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    check("rst ready", 64'(resp_ready8), 64'd1);
    check("rst send", 64'(tx_send8), 64'd0);
    check("rst data", 64'(tx_data8), 64'd0);
    check("rst fd", 64'(frame_done8), 64'd0);
    check("rst err", 64'(ack_err8), 64'd0);
    check("rst ready1", 64'(resp_ready1), 64'd1);

    blen8 = 160;
    run_frame8("nominal", 64'hDEADBEEF00000000, 1'b1);

    for (int i = 0; i < 6; i++) begin
      blen8 = tbl[i].blen;
      run_frame8($sformatf("vec%0d", i), tbl[i].d, 1'b1);
      check($sformatf("vec%0d chk", i), 64'(cap8[cap8.size()-1]), 64'(tbl[i].chk));
    end

    for (int i = 0; i < 10; i++) begin
      blen8 = $urandom_range(1, 12);
      d = {$urandom, $urandom};
      run_frame8($sformatf("rnd%0d", i), d, 1'b1);
    end

    // Back-pressure: transmitter busy across the accept for 100 cycles.
    blen8 = 5; hold8 = 1'b1;
    base = cap8.size(); fdb = fd_cnt8; sends = 0;
    accept8("bp", 64'h0102030405060708, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); @(negedge clk);
      if (tx_send8) sends++;
    end
    check("bp held", 64'(sends), 64'd0);
    hold8 = 1'b0;
    @(posedge clk); @(negedge clk);
    check("bp send", 64'(tx_send8), 64'd1);
    check("bp hdr", 64'(tx_data8), 64'hA5);
    wait_fd8("bp", fdb);
    check_cap("bp", 1'b0, base, 8, {64'h0, 64'h0102030405060708});

    // Ack timeout with tx_busy stuck low.
    tie0_8 = 1'b1;
    sc = send_cnt8; fdb = fd_cnt8;
    accept8("tmo", 64'hCAFEF00D12345678, 1'b1);
    repeat (14) begin @(posedge clk); @(negedge clk); end
    check("tmo early", 64'(ack_err8), 64'd0);
    check("tmo single", 64'(tx_send8), 64'd0);
    @(posedge clk); @(negedge clk);
    check("tmo err", 64'(ack_err8), 64'd1);
    check("tmo ready", 64'(resp_ready8), 64'd1);
    repeat (5) @(negedge clk);
    check("tmo sends", 64'(send_cnt8 - sc), 64'd1);
    check("tmo no fd", 64'(fd_cnt8 - fdb), 64'd0);
    check("tmo sticky", 64'(ack_err8), 64'd1);
    tie0_8 = 1'b0;
    blen8 = 4;
    run_frame8("post-tmo", 64'h55AA55AA00FF00FF, 1'b1);

    // Reset one cycle after the third byte's send.
    blen8 = 20; fdb = fd_cnt8;
    accept8("mrst", 64'h1122334455667788, 1'b1);
    n = 1; sc = 0;
    while (n < 3 && sc < 2000) begin
      @(negedge clk); sc++;
      if (tx_send8) n++;
    end
    check("mrst 3rd send", 64'(n), 64'd3);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); @(negedge clk); rst = 1'b0;
    check("mrst send", 64'(tx_send8), 64'd0);
    check("mrst ready", 64'(resp_ready8), 64'd1);
    check("mrst data", 64'(tx_data8), 64'd0);
    check("mrst err", 64'(ack_err8), 64'd0);
    run_frame8("mrst new", 64'h0000000000000001, 1'b0);
    check("mrst new chk", 64'(cap8[cap8.size()-1]), 64'h01);
    check("mrst one fd", 64'(fd_cnt8 - fdb), 64'd1);

    // A competing resp_valid mid-frame must not disturb the frame.
    blen8 = 6;
    base = cap8.size(); fdb = fd_cnt8;
    accept8("ign", 64'h0011223344556677, 1'b1);
    sc = 0;
    while (cap8.size() - base < 4 && sc < 2000) begin @(negedge clk); sc++; end
    resp_data8 = 64'hFFEEDDCCBBAA9988; resp_valid8 = 1'b1;
    check("ign not ready", 64'(resp_ready8), 64'd0);
    @(posedge clk); @(negedge clk);
    resp_valid8 = 1'b0;
    wait_fd8("ign", fdb);
    check_cap("ign", 1'b0, base, 8, {64'h0, 64'h0011223344556677});

    blen1 = 4;
    run_frame1("min", 8'h3C);
    for (int i = 0; i < 4; i++) begin
      blen1 = $urandom_range(1, 8);
      run_frame1($sformatf("min rnd%0d", i), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/puf_resp_sender.md
PUF_RESP_SENDER -- requirements
Module: puf_resp_sender

Interface
REQ-001 The parameter RESP_BYTES SHALL default to 8 and gives the number of response bytes per frame (legal range 1..16).
REQ-002 The parameter HEADER SHALL default to 8'hA5 and is the frame header byte.
REQ-003 The parameter ACK_TIMEOUT SHALL default to 15 and is the number of cycles allowed for tx_busy to rise after tx_send.
REQ-004 The port clk SHALL be an input, 1 bit wide, and is the single clock; all logic is on its rising edge.
REQ-005 The port rst SHALL be an input, 1 bit wide, and is the synchronous, active-high reset.
REQ-006 The port resp_data SHALL be an input, 8*RESP_BYTES bits wide, and carries the PUF response word.
REQ-007 The port resp_valid SHALL be an input, 1 bit wide, and indicates that resp_data is valid.
REQ-008 The port resp_ready SHALL be an output, 1 bit wide, and indicates that the block can accept a response.
REQ-009 The port tx_data SHALL be an output, 8 bits wide, and is the byte presented to the UART transmitter.
REQ-010 The port tx_send SHALL be an output, 1 bit wide, and is the one-cycle send request to the UART transmitter.
REQ-011 The port tx_busy SHALL be an input, 1 bit wide, and is the busy flag from the UART transmitter.
REQ-012 The port frame_done SHALL be an output, 1 bit wide, and pulses for one cycle when a frame completes.
REQ-013 The port ack_err SHALL be an output, 1 bit wide, and is a sticky flag for a transmitter-acknowledge timeout.

Function
REQ-014 The frame SHALL be sent in this byte order: HEADER, then the response bytes MSB-first (resp_data[8*RESP_BYTES-1 -: 8] first), then CHK, where CHK is the XOR of all response bytes (HEADER excluded).
REQ-015 The FSM SHALL have the states IDLE, ISSUE, ACK and DRAIN.
REQ-016 resp_ready SHALL be 1 only in IDLE, and the transfer SHALL occur when resp_valid and resp_ready are both 1; on that cycle the block captures resp_data into an internal register, clears CHK, sets the byte index to 0, clears ack_err and moves to ISSUE.
REQ-017 In ISSUE with tx_busy=0, the block SHALL drive tx_send=1 for exactly one cycle with tx_data set to the current byte, then move to ACK.
REQ-018 In ISSUE with tx_busy=1, the block SHALL hold in ISSUE with tx_send=0.
REQ-019 In ACK, tx_busy=1 SHALL move the FSM to DRAIN and clear the timeout counter.
REQ-020 In ACK, if tx_busy stays 0 for ACK_TIMEOUT cycles, the block SHALL set ack_err=1, abandon the frame and return to IDLE without pulsing frame_done.
REQ-021 In DRAIN, tx_busy=0 SHALL cause a return to ISSUE with the index incremented if the byte was not the last.
REQ-022 In DRAIN, tx_busy=0 on the last byte (CHK) SHALL cause a return to IDLE with frame_done=1 for one cycle, with resp_ready=1 in that same cycle.
REQ-023 tx_data SHALL stay stable from ISSUE through the end of DRAIN for each byte.
REQ-024 CHK SHALL be accumulated as each response byte is issued.
REQ-025 Latency SHALL be as follows: if tx_busy=0, tx_send asserts in the cycle after the accept edge.
REQ-026 All outputs SHALL be registered.
REQ-027 resp_valid while not in IDLE SHALL be ignored, with no capture and no effect on the frame in flight.
REQ-028 A frame of RESP_BYTES=1 SHALL be exactly 3 bytes; the byte index is sized $clog2(RESP_BYTES+2) bits and SHALL never wrap within a frame.
REQ-029 The timeout counter SHALL saturate at ACK_TIMEOUT and SHALL never wrap.

Reset
REQ-030 rst=1 at a clock edge SHALL force the state to IDLE from any state, including mid-frame.
REQ-031 On reset, outputs SHALL take these values: tx_send=0, tx_data=8'h00, frame_done=0, ack_err=0, resp_ready=1 (from the first cycle after reset).
REQ-032 On reset, the captured response, CHK, the index and the counter SHALL be cleared, and the partial frame SHALL NOT be resumed.

Structure
REQ-033 A shared package puf_uart_pkg SHALL hold the state enum, the HEADER default constant and a frame-length function (RESP_BYTES+2).
REQ-034 puf_resp_sender SHALL be a single module with no sub-module; uart_tx is instantiated by the parent, with tx_data/tx_send/tx_busy connected to its data/send/busy.

Verification
REQ-035 Nominal frame: resp_data=64'hDEADBEEF00000000 with tx_busy modelled by uart_tx (CLOCKS_PER_BIT=16) -> decoded serial stream A5 DE AD BE EF 00 00 00 00 22, then one frame_done pulse.
REQ-036 Back-pressure: tx_busy held 1 for 100 cycles when the response is accepted -> tx_send stays 0 for those cycles, then asserts in the first ISSUE cycle that samples tx_busy=0, and the frame completes intact.
REQ-037 Ack timeout: tx_busy tied 0 -> one tx_send pulse, ack_err=1 after 15 ACK cycles, no frame_done, resp_ready=1; the next accepted response clears ack_err.
REQ-038 Reset mid-frame: rst asserted one cycle after the third byte's tx_send -> tx_send=0, state IDLE, resp_ready=1; a new response 64'h0000000000000001 yields A5 00 00 00 00 00 00 00 01 01.
REQ-039 Ignored input: resp_valid pulsed with a different word mid-frame -> the frame bytes are unchanged and exactly one frame_done pulse occurs.
REQ-040 Minimum size: RESP_BYTES=1 with resp_data=8'h3C -> bytes A5 3C 3C.
